// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared pipeline definitions: hazard FSM state encoding, operand forward-select
// codes and counter saturation limits.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LD_STALL = 2'd1,
        FREEZE   = 2'd2
    } state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    localparam logic [15:0] STALL_MAX = 16'hFFFF;
    localparam logic [7:0]  ANNUL_MAX = 8'hFF;

    // r0 is hardwired to zero, so it can never be a real dependency.
    function automatic logic regMatch(input logic [4:0] src, input logic [4:0] dst);
        return (src == dst) && (src != 5'd0);
    endfunction

endpackage

// File: rtl/fwd_select.sv
// Operand bypass selector for one ID source register; the youngest producer wins
// and EX-stage loads are skipped because their data does not exist yet.
module fwd_select
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic [4:0] rs_i,
    input  logic [4:0] exRd_i,
    input  logic       exRfEn_i,
    input  logic       exLoad_i,
    input  logic [4:0] memRd_i,
    input  logic       memRfEn_i,
    input  logic [4:0] wbRd_i,
    input  logic       wbRfEn_i,
    output logic [1:0] sel_o
);

    always_comb begin
        sel_o = FWD_RF;
        if (exRfEn_i && !exLoad_i && regMatch(rs_i, exRd_i)) begin
            sel_o = FWD_EX;
        end else if (memRfEn_i && regMatch(rs_i, memRd_i)) begin
            sel_o = FWD_MEM;
        end else if (wbRfEn_i && regMatch(rs_i, wbRd_i)) begin
            sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, memory-wait freezes, annulled
// delay-slot flushes, operand forwarding and saturating event counters.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic [4:0]  ID_rs1,
    input  logic [4:0]  ID_rs2,
    input  logic        ID_rs1_used,
    input  logic        ID_rs2_used,
    input  logic [4:0]  EX_RD,
    input  logic [4:0]  MEM_RD,
    input  logic [4:0]  WB_RD,
    input  logic        EX_RF_enable,
    input  logic        MEM_RF_enable,
    input  logic        WB_RF_enable,
    input  logic        EX_load,
    input  logic        ID_branch,
    input  logic        ID_taken,
    input  logic        ID_annul,
    input  logic        mem_wait,
    output logic        PC_LE,
    output logic        IF_ID_LE,
    output logic        ID_EX_LE,
    output logic        EX_MEM_LE,
    output logic        IF_ID_reset,
    output logic        ID_EX_reset,
    output logic [1:0]  fwd_A,
    output logic [1:0]  fwd_B,
    output logic [15:0] stall_cycles,
    output logic [7:0]  annul_count
);

    state_e      state_q, state_d;
    logic [15:0] stallCnt_q, stallCnt_d;
    logic [7:0]  annulCnt_q, annulCnt_d;
    logic        loadUse;
    logic        annulSlot;
    logic        annulEvt;

    assign loadUse = EX_load && EX_RF_enable && (EX_RD != 5'd0) &&
                     ((ID_rs1_used && (ID_rs1 == EX_RD)) ||
                      (ID_rs2_used && (ID_rs2 == EX_RD)));
    assign annulSlot = ID_branch && ID_annul && !ID_taken;

    fwd_select uFwdA (
        .rs_i      (ID_rs1),
        .exRd_i    (EX_RD),
        .exRfEn_i  (EX_RF_enable),
        .exLoad_i  (EX_load),
        .memRd_i   (MEM_RD),
        .memRfEn_i (MEM_RF_enable),
        .wbRd_i    (WB_RD),
        .wbRfEn_i  (WB_RF_enable),
        .sel_o     (fwd_A)
    );

    fwd_select uFwdB (
        .rs_i      (ID_rs2),
        .exRd_i    (EX_RD),
        .exRfEn_i  (EX_RF_enable),
        .exLoad_i  (EX_load),
        .memRd_i   (MEM_RD),
        .memRfEn_i (MEM_RF_enable),
        .wbRd_i    (WB_RD),
        .wbRfEn_i  (WB_RF_enable),
        .sel_o     (fwd_B)
    );

    always_comb begin
        state_d     = state_q;
        PC_LE       = 1'b1;
        IF_ID_LE    = 1'b1;
        ID_EX_LE    = 1'b1;
        EX_MEM_LE   = 1'b1;
        IF_ID_reset = 1'b0;
        ID_EX_reset = 1'b0;
        annulEvt    = 1'b0;

        case (state_q)
            RUN: begin
                if (mem_wait) begin
                    {PC_LE, IF_ID_LE, ID_EX_LE, EX_MEM_LE} = 4'b0000;
                    state_d = FREEZE;
                end else if (loadUse) begin
                    PC_LE       = 1'b0;
                    IF_ID_LE    = 1'b0;
                    ID_EX_reset = 1'b1;
                    state_d     = LD_STALL;
                end else if (annulSlot) begin
                    IF_ID_reset = 1'b1;
                    annulEvt    = 1'b1;
                end
            end
            LD_STALL, FREEZE: begin
                if (mem_wait) begin
                    {PC_LE, IF_ID_LE, ID_EX_LE, EX_MEM_LE} = 4'b0000;
                    state_d = FREEZE;
                end else begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase

        // Reset must present idle controls even if hazard inputs are already active.
        if (!clr) begin
            state_d     = RUN;
            PC_LE       = 1'b1;
            IF_ID_LE    = 1'b1;
            ID_EX_LE    = 1'b1;
            EX_MEM_LE   = 1'b1;
            IF_ID_reset = 1'b0;
            ID_EX_reset = 1'b0;
            annulEvt    = 1'b0;
        end
    end

    always_comb begin
        stallCnt_d = stallCnt_q;
        annulCnt_d = annulCnt_q;
        if (!PC_LE && (stallCnt_q != STALL_MAX)) begin
            stallCnt_d = stallCnt_q + 16'd1;
        end
        if (annulEvt && (annulCnt_q != ANNUL_MAX)) begin
            annulCnt_d = annulCnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q    <= RUN;
            stallCnt_q <= 16'd0;
            annulCnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            stallCnt_q <= stallCnt_d;
            annulCnt_q <= annulCnt_d;
        end
    end

    assign stall_cycles = stallCnt_q;
    assign annul_count  = annulCnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed, table-driven bench for pipeline_hazard_ctrl with hand sequences for
// the multi-cycle stall, freeze, reset and saturation cases.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        clr;
    logic [4:0]  ID_rs1, ID_rs2, EX_RD, MEM_RD, WB_RD;
    logic        ID_rs1_used, ID_rs2_used;
    logic        EX_RF_enable, MEM_RF_enable, WB_RF_enable, EX_load;
    logic        ID_branch, ID_taken, ID_annul, mem_wait;
    logic        PC_LE, IF_ID_LE, ID_EX_LE, EX_MEM_LE, IF_ID_reset, ID_EX_reset;
    logic [1:0]  fwd_A, fwd_B;
    logic [15:0] stall_cycles;
    logic [7:0]  annul_count;
    logic [9:0]  ctl;

    int nApplied = 0;
    int nMiss    = 0;

    // Control groups {PC_LE, IF_ID_LE, ID_EX_LE, EX_MEM_LE, IF_ID_reset, ID_EX_reset}
    localparam logic [5:0] DEF = 6'b111100;
    localparam logic [5:0] LU  = 6'b001101;
    localparam logic [5:0] FRZ = 6'b000000;
    localparam logic [5:0] ANN = 6'b111110;

    typedef struct {
        logic [4:0]  rs1, rs2, exRd, memRd, wbRd;
        logic        u1, u2, exEn, exLd, memEn, wbEn, br, tk, an, mw;
        logic [9:0]  expCtl;
        logic [15:0] expStall;
        logic [7:0]  expAnnul;
    } vec_t;

    vec_t tbl[19];
    vec_t idle, luVec, mwVec, annVec;

    pipeline_hazard_ctrl dut (
        .clk           (clk),
        .clr           (clr),
        .ID_rs1        (ID_rs1),
        .ID_rs2        (ID_rs2),
        .ID_rs1_used   (ID_rs1_used),
        .ID_rs2_used   (ID_rs2_used),
        .EX_RD         (EX_RD),
        .MEM_RD        (MEM_RD),
        .WB_RD         (WB_RD),
        .EX_RF_enable  (EX_RF_enable),
        .MEM_RF_enable (MEM_RF_enable),
        .WB_RF_enable  (WB_RF_enable),
        .EX_load       (EX_load),
        .ID_branch     (ID_branch),
        .ID_taken      (ID_taken),
        .ID_annul      (ID_annul),
        .mem_wait      (mem_wait),
        .PC_LE         (PC_LE),
        .IF_ID_LE      (IF_ID_LE),
        .ID_EX_LE      (ID_EX_LE),
        .EX_MEM_LE     (EX_MEM_LE),
        .IF_ID_reset   (IF_ID_reset),
        .ID_EX_reset   (ID_EX_reset),
        .fwd_A         (fwd_A),
        .fwd_B         (fwd_B),
        .stall_cycles  (stall_cycles),
        .annul_count   (annul_count)
    );

    assign ctl = {PC_LE, IF_ID_LE, ID_EX_LE, EX_MEM_LE, IF_ID_reset, ID_EX_reset, fwd_A, fwd_B};

    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
        input logic [4:0] exRd, input logic exEn, input logic exLd,
        input logic [4:0] memRd, input logic memEn, input logic [4:0] wbRd, input logic wbEn,
        input logic br, input logic tk, input logic an, input logic mw,
        input logic [9:0] expCtl, input logic [15:0] expStall, input logic [7:0] expAnnul);
        vec_t v;
        v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
        v.exRd = exRd; v.exEn = exEn; v.exLd = exLd;
        v.memRd = memRd; v.memEn = memEn; v.wbRd = wbRd; v.wbEn = wbEn;
        v.br = br; v.tk = tk; v.an = an; v.mw = mw;
        v.expCtl = expCtl; v.expStall = expStall; v.expAnnul = expAnnul;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        ID_rs1 = v.rs1;   ID_rs1_used = v.u1;
        ID_rs2 = v.rs2;   ID_rs2_used = v.u2;
        EX_RD = v.exRd;   EX_RF_enable = v.exEn;   EX_load = v.exLd;
        MEM_RD = v.memRd; MEM_RF_enable = v.memEn;
        WB_RD = v.wbRd;   WB_RF_enable = v.wbEn;
        ID_branch = v.br; ID_taken = v.tk; ID_annul = v.an;
        mem_wait = v.mw;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nApplied++;
        if (act !== exp) begin
            nMiss++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Pulse reset in the low clock phase and release with v already driven.
    task automatic resetWith(input vec_t v);
        @(negedge clk);
        clr = 1'b0;
        applyStimulus(v);
        #1;
        clr = 1'b1;
        #1;
    endtask

    initial begin
        clr = 1'b0;
        idle   = mk(0,0,0,0, 0,0,0, 0,0,0,0, 0,0,0,0, {DEF,4'b0000}, 0, 0);
        luVec  = mk(5,1,0,0, 5,1,1, 0,0,0,0, 0,0,0,0, {LU,4'b0000},  1, 0);
        mwVec  = mk(0,0,0,0, 0,0,0, 0,0,0,0, 0,0,0,1, {FRZ,4'b0000}, 1, 0);
        annVec = mk(0,0,0,0, 0,0,0, 0,0,0,0, 1,0,1,0, {ANN,4'b0000}, 0, 1);
        applyStimulus(idle);

        tbl[0]  = luVec;
        tbl[1]  = mk(0,1,0,0, 0,1,1, 0,1,0,1, 0,0,0,0, {DEF,2'b00,2'b00}, 0, 0);
        tbl[2]  = mk(3,1,7,1, 7,1,0, 7,1,7,1, 0,0,0,0, {DEF,2'b00,2'b01}, 0, 0);
        tbl[3]  = mk(3,1,7,1, 7,0,0, 7,1,7,1, 0,0,0,0, {DEF,2'b00,2'b10}, 0, 0);
        tbl[4]  = mk(3,1,7,1, 7,0,0, 7,0,7,1, 0,0,0,0, {DEF,2'b00,2'b11}, 0, 0);
        tbl[5]  = mk(7,1,9,1, 7,1,0, 9,1,9,1, 0,0,0,0, {DEF,2'b01,2'b10}, 0, 0);
        tbl[6]  = mk(7,1,0,0, 7,1,1, 7,1,0,0, 0,0,0,0, {LU,2'b10,2'b00},  1, 0);
        tbl[7]  = mk(0,0,4,1, 4,1,1, 0,0,0,0, 0,0,0,0, {LU,2'b00,2'b00},  1, 0);
        tbl[8]  = mk(0,0,4,0, 4,1,1, 0,0,0,0, 0,0,0,0, {DEF,2'b00,2'b00}, 0, 0);
        tbl[9]  = mk(4,1,0,0, 4,0,1, 0,0,0,0, 0,0,0,0, {DEF,2'b00,2'b00}, 0, 0);
        tbl[10] = annVec;
        tbl[11] = mk(0,0,0,0, 0,0,0, 0,0,0,0, 1,1,1,0, {DEF,2'b00,2'b00}, 0, 0);
        tbl[12] = mk(0,0,0,0, 0,0,0, 0,0,0,0, 1,0,0,0, {DEF,2'b00,2'b00}, 0, 0);
        tbl[13] = mwVec;
        tbl[14] = mk(5,1,0,0, 5,1,1, 0,0,0,0, 0,0,0,1, {FRZ,2'b00,2'b00}, 1, 0);
        tbl[15] = mk(5,1,0,0, 5,1,1, 0,0,0,0, 1,0,1,0, {LU,2'b00,2'b00},  1, 0);
        tbl[16] = mk(12,1,0,0, 0,0,0, 12,0,12,1, 0,0,0,0, {DEF,2'b11,2'b00}, 0, 0);
        tbl[17] = mk(6,0,0,0, 6,1,0, 0,0,0,0, 0,0,0,0, {DEF,2'b01,2'b00}, 0, 0);
        tbl[18] = mk(0,0,9,1, 0,0,0, 9,1,0,0, 0,0,0,1, {FRZ,2'b00,2'b10}, 1, 0);

        // Each vector starts from a fresh RUN state.
        for (int i = 0; i < 19; i++) begin
            resetWith(tbl[i]);
            checkOutput($sformatf("vec%0d ctl", i), 32'(ctl), 32'(tbl[i].expCtl));
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d stall_cycles", i), 32'(stall_cycles), 32'(tbl[i].expStall));
            checkOutput($sformatf("vec%0d annul_count", i), 32'(annul_count), 32'(tbl[i].expAnnul));
        end

        // Controls stay idle while in reset, even with hazards pending.
        @(negedge clk);
        clr = 1'b0;
        applyStimulus(mk(7,1,0,0, 7,1,1, 7,1,0,0, 0,0,0,1, 10'd0, 0, 0));
        #1;
        checkOutput("in-reset ctl", 32'(ctl), 32'({DEF,2'b10,2'b00}));
        @(posedge clk);
        #1;
        checkOutput("in-reset stall_cycles", 32'(stall_cycles), 32'd0);
        clr = 1'b1;

        // Load-use: one stall cycle, LD_STALL masks the hazard, then back in RUN.
        resetWith(luVec);
        checkOutput("lu run ctl", 32'(ctl), 32'({LU,4'b0000}));
        @(posedge clk);
        #1;
        checkOutput("lu stall count", 32'(stall_cycles), 32'd1);
        checkOutput("lu ldstall ctl", 32'(ctl), 32'({DEF,4'b0000}));
        @(posedge clk);
        #1;
        checkOutput("lu back-in-run ctl", 32'(ctl), 32'({LU,4'b0000}));
        checkOutput("lu count held", 32'(stall_cycles), 32'd1);
        @(posedge clk);
        #1;
        mem_wait = 1'b1;
        #1;
        checkOutput("ldstall+wait ctl", 32'(ctl), 32'({FRZ,4'b0000}));
        @(posedge clk);
        #1;
        checkOutput("ldstall->freeze ctl", 32'(ctl), 32'({FRZ,4'b0000}));
        checkOutput("ldstall->freeze count", 32'(stall_cycles), 32'd3);
        mem_wait = 1'b0;
        #1;
        checkOutput("freeze release ctl", 32'(ctl), 32'({DEF,4'b0000}));
        @(posedge clk);
        #1;
        checkOutput("freeze->run ctl", 32'(ctl), 32'({LU,4'b0000}));

        // mem_wait held three cycles on top of a load-use.
        resetWith(mk(5,1,0,0, 5,1,1, 0,0,0,0, 0,0,0,1, 10'd0, 0, 0));
        checkOutput("frz3 cycle1 ctl", 32'(ctl), 32'({FRZ,4'b0000}));
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("frz3 count%0d", i), 32'(stall_cycles), 32'(i));
            if (i < 3) checkOutput($sformatf("frz3 cycle%0d ctl", i + 1), 32'(ctl), 32'({FRZ,4'b0000}));
        end
        mem_wait = 1'b0;
        #1;
        checkOutput("frz3 release ctl", 32'(ctl), 32'({DEF,4'b0000}));
        @(posedge clk);
        #1;
        checkOutput("frz3 final count", 32'(stall_cycles), 32'd3);
        checkOutput("frz3 run ctl", 32'(ctl), 32'({LU,4'b0000}));

        // Annul flush lasts only while the annulled branch sits in ID.
        resetWith(annVec);
        checkOutput("annul ctl", 32'(ctl), 32'({ANN,4'b0000}));
        @(posedge clk);
        #1;
        checkOutput("annul count", 32'(annul_count), 32'd1);
        applyStimulus(idle);
        #1;
        checkOutput("annul next ctl", 32'(ctl), 32'({DEF,4'b0000}));
        @(posedge clk);
        #1;
        checkOutput("annul count held", 32'(annul_count), 32'd1);

        // Reset while frozen: RUN immediately, counters cleared.
        resetWith(mwVec);
        @(posedge clk);
        #1;
        clr = 1'b0;
        #1;
        checkOutput("clr in freeze ctl", 32'(ctl), 32'({DEF,4'b0000}));
        checkOutput("clr in freeze stall", 32'(stall_cycles), 32'd0);
        applyStimulus(annVec);
        #1;
        clr = 1'b1;
        #1;
        checkOutput("after clr run ctl", 32'(ctl), 32'({ANN,4'b0000}));
        @(posedge clk);
        #1;
        checkOutput("after clr annul", 32'(annul_count), 32'd1);
        checkOutput("after clr stall", 32'(stall_cycles), 32'd0);

        // Reset while in LD_STALL: no pending stall remains.
        resetWith(luVec);
        @(posedge clk);
        #1;
        clr = 1'b0;
        #1;
        clr = 1'b1;
        #1;
        checkOutput("clr in ldstall ctl", 32'(ctl), 32'({LU,4'b0000}));
        @(posedge clk);
        #1;
        checkOutput("clr in ldstall count", 32'(stall_cycles), 32'd1);

        // Saturation of both counters.
        resetWith(annVec);
        repeat (300) @(posedge clk);
        #1;
        checkOutput("annul saturate", 32'(annul_count), 32'h0000_00FF);
        resetWith(mwVec);
        repeat (65600) @(posedge clk);
        #1;
        checkOutput("stall saturate", 32'(stall_cycles), 32'h0000_FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiss);
        $finish;
    end

endmodule
